// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the IF and MEM pipeline stages.
// MEM has priority, but its consecutive grants are bounded while a fetch is waiting.
module mem_port_arbiter #(
    parameter int SIZE        = 31,
    parameter int MAX_MEM_RUN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic mem_req,
    input  logic mem_we,
    input  logic port_ready,
    output logic port_valid,
    output logic port_we,
    output logic sel,
    output logic if_ack,
    output logic mem_ack,
    output logic if_stall,
    output logic mem_stall
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_MEM_RUN);

    if (SIZE < 0 || MAX_MEM_RUN < 1 || MAX_MEM_RUN > 15) begin : g_bad_param
        $error("mem_port_arbiter: illegal parameter value");
    end

    state_t     state, next_state, decision;
    logic [3:0] run_cnt;
    logic       arb, grant_mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // A new decision is taken when idle or when the current beat completes.
    always_comb begin
        arb        = (state == IDLE) || port_ready;
        grant_mem  = mem_req && ((run_cnt < MAX_RUN) || !if_req);
        decision   = grant_mem ? BUSY_MEM : if_req ? BUSY_IF : IDLE;
        next_state = arb ? decision : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel     <= 1'b0;
            port_we <= 1'b0;
            run_cnt <= '0;
        end else if (arb) begin
            port_we <= grant_mem && mem_we;
            if (decision != IDLE) sel <= grant_mem;
            if (grant_mem && if_req)   run_cnt <= (run_cnt == MAX_RUN) ? run_cnt : run_cnt + 4'd1;
            else if (decision == BUSY_IF) run_cnt <= '0;
        end
    end

    always_comb begin
        port_valid = state != IDLE;
        if_ack     = (state == BUSY_IF) && port_ready;
        mem_ack    = (state == BUSY_MEM) && port_ready;
        if_stall   = if_req && !if_ack;
        mem_stall  = mem_req && !mem_ack;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a seeded random soak, checked every
// cycle against a transaction-level model of the port owner and the MEM streak.
module tb_mem_port_arbiter;
    localparam int MAX_RUN = 4;

    logic clk = 1'b0;
    logic reset_n, if_req, mem_req, mem_we, port_ready;
    logic port_valid, port_we, sel, if_ack, mem_ack, if_stall, mem_stall;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter #(.SIZE(31), .MAX_MEM_RUN(MAX_RUN)) dut (
        .clk(clk), .reset_n(reset_n), .if_req(if_req), .mem_req(mem_req),
        .mem_we(mem_we), .port_ready(port_ready), .port_valid(port_valid),
        .port_we(port_we), .sel(sel), .if_ack(if_ack), .mem_ack(mem_ack),
        .if_stall(if_stall), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Model: who owns the port (0 none, 1 fetch, 2 mem), the mux/strobe it was
    // given, and how many MEM grants in a row were made while a fetch waited.
    int   owner  = 0;
    int   streak = 0;
    logic m_sel  = 1'b0;
    logic m_we   = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner = 0; streak = 0; m_sel = 1'b0; m_we = 1'b0;
        end else if (owner == 0 || port_ready) begin
            if (mem_req && (!if_req || streak < MAX_RUN)) begin
                owner = 2; m_sel = 1'b1; m_we = mem_we;
                if (if_req && streak < MAX_RUN) streak++;
            end else if (if_req) begin
                owner = 1; m_sel = 1'b0; m_we = 1'b0; streak = 0;
            end else begin
                owner = 0; m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic e_if_ack, e_mem_ack;
        e_if_ack  = (owner == 1) && port_ready;
        e_mem_ack = (owner == 2) && port_ready;
        chk("m_port_valid", port_valid, owner != 0);
        chk("m_sel", sel, m_sel);
        chk("m_port_we", port_we, m_we);
        chk("m_if_ack", if_ack, e_if_ack);
        chk("m_mem_ack", mem_ack, e_mem_ack);
        chk("m_if_stall", if_stall, if_req && !e_if_ack);
        chk("m_mem_stall", mem_stall, mem_req && !e_mem_ack);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [9:0] exp_sel_seq;
    logic [9:0] exp_we_seq;

    initial begin
        reset_n = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; port_ready = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        chk("rst_valid", port_valid, 1'b0);
        chk("rst_sel", sel, 1'b0);
        chk("rst_we", port_we, 1'b0);
        chk("rst_mem_ack", mem_ack, 1'b0);
        if_req = 1'b1;
        #1;
        chk("rst_if_stall", if_stall, 1'b1);
        chk("rst_if_ack", if_ack, 1'b0);
        if_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        step;

        // Single fetch: grant one edge after request, ack when ready.
        if_req = 1'b1;
        #1;
        chk("if_c0_stall", if_stall, 1'b1);
        chk("if_c0_valid", port_valid, 1'b0);
        step;
        chk("if_c1_valid", port_valid, 1'b1);
        chk("if_c1_sel", sel, 1'b0);
        chk("if_c1_stall", if_stall, 1'b1);
        chk("if_c1_ack", if_ack, 1'b0);
        step;
        port_ready = 1'b1;
        #1;
        chk("if_c2_ack", if_ack, 1'b1);
        chk("if_c2_stall", if_stall, 1'b0);
        step;

        // Both requesting with ready every cycle: four MEM beats then one IF beat.
        mem_req = 1'b1; mem_we = 1'b1;
        exp_sel_seq = 10'b0111101111;
        exp_we_seq  = 10'b0111101111;
        for (int i = 0; i < 10; i++) begin
            step;
            chk("both_valid", port_valid, 1'b1);
            chk("both_sel", sel, exp_sel_seq[i]);
            chk("both_we", port_we, exp_we_seq[i]);
        end
        if_req = 1'b0; mem_req = 1'b0;
        step;
        chk("idle_valid", port_valid, 1'b0);
        chk("idle_spurious_if_ack", if_ack, 1'b0);
        chk("idle_spurious_mem_ack", mem_ack, 1'b0);
        step;
        chk("idle_stays", port_valid, 1'b0);

        // Wait states: strobe and mux stay put while mem_we wiggles.
        port_ready = 1'b0; mem_req = 1'b1; mem_we = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            mem_we = ~mem_we;
            #1;
            chk("ws_valid", port_valid, 1'b1);
            chk("ws_sel", sel, 1'b1);
            chk("ws_we", port_we, 1'b0);
            chk("ws_no_ack", mem_ack, 1'b0);
            step;
        end
        port_ready = 1'b1;
        #1;
        chk("ws_ack", mem_ack, 1'b1);
        mem_req = 1'b0;
        step;
        port_ready = 1'b0;

        // Reset in the middle of a MEM beat abandons it.
        mem_req = 1'b1;
        step;
        chk("mr_granted", sel, 1'b1);
        #2 reset_n = 1'b0; port_ready = 1'b1;
        #1;
        chk("mr_valid", port_valid, 1'b0);
        chk("mr_sel", sel, 1'b0);
        chk("mr_no_ack", mem_ack, 1'b0);
        step;
        #3 reset_n = 1'b1; port_ready = 1'b0;
        step;
        chk("mr_resume_valid", port_valid, 1'b1);
        chk("mr_resume_sel", sel, 1'b1);
        port_ready = 1'b1; mem_req = 1'b0;
        step;
        port_ready = 1'b0;

        // Fetch request dropped mid-beat still completes.
        if_req = 1'b1;
        step;
        if_req = 1'b0;
        #1;
        chk("drop_valid", port_valid, 1'b1);
        chk("drop_no_ack", if_ack, 1'b0);
        step;
        port_ready = 1'b1;
        #1;
        chk("drop_ack", if_ack, 1'b1);
        step;
        port_ready = 1'b0;

        for (int i = 0; i < 400; i++) begin
            step;
            if_req     = $urandom_range(0, 3) != 0;
            mem_req    = $urandom_range(0, 3) != 0;
            mem_we     = 1'($urandom_range(0, 1));
            port_ready = $urandom_range(0, 2) != 0;
        end
        step;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
